// File: rtl/fetch_pkg.sv
// Shared fetch-pipeline definitions: immediate-format selects, RV32I opcodes
// and the predecoded entry payload held in the fetch buffer.
package fetch_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned IMM_SEL_W = 4;
  localparam int unsigned OPCODE_W  = 7;

  localparam logic [IMM_SEL_W-1:0] IMM_NONE = 4'd0;
  localparam logic [IMM_SEL_W-1:0] IMM_I    = 4'd1;
  localparam logic [IMM_SEL_W-1:0] IMM_S    = 4'd2;
  localparam logic [IMM_SEL_W-1:0] IMM_B    = 4'd3;
  localparam logic [IMM_SEL_W-1:0] IMM_U    = 4'd4;
  localparam logic [IMM_SEL_W-1:0] IMM_J    = 4'd5;

  localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [INSTR_W-1:0]   instr;
    logic [IMM_SEL_W-1:0] imm_sel;
    logic                 illegal;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational opcode predecode: immediate format select and illegal flag.
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [INSTR_W-1:0]   instr_i,
  output logic [IMM_SEL_W-1:0] imm_sel_o,
  output logic                 illegal_o
);

  // Only the opcode field matters here; upper bits are deliberately ignored.
  logic unused_upper;
  assign unused_upper = ^instr_i[INSTR_W-1:OPCODE_W];

  always_comb begin
    imm_sel_o = IMM_NONE;
    illegal_o = 1'b0;
    case (instr_i[OPCODE_W-1:0])
      OPC_LUI, OPC_AUIPC:              imm_sel_o = IMM_U;
      OPC_JAL:                         imm_sel_o = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:  imm_sel_o = IMM_I;
      OPC_STORE:                       imm_sel_o = IMM_S;
      OPC_BRANCH:                      imm_sel_o = IMM_B;
      OPC_OP, OPC_FENCE, OPC_SYSTEM:   imm_sel_o = IMM_NONE;
      default:                         illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_buf_ctl.sv
// Fetch-to-decode FIFO with predecode on the push path, valid/ready on both
// sides and a single-cycle flush for redirects.
module fetch_buf_ctl
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned PC_W  = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  input  logic [PC_W-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_W-1:0]   out_instr,
  output logic [PC_W-1:0]      out_pc,
  output logic [IMM_SEL_W-1:0] out_imm_sel,
  output logic                 out_illegal,
  output logic [CNT_W-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  fetch_entry_t     entry_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_q    [DEPTH];

  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic             push, pop;

  fetch_predecode u_predecode (
    .instr_i   (in_instr),
    .imm_sel_o (push_entry.imm_sel),
    .illegal_o (push_entry.illegal)
  );
  assign push_entry.instr = in_instr;

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally unreset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_mem_q[wr_ptr_q] <= push_entry;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  assign head_entry  = entry_mem_q[rd_ptr_q];
  assign out_instr   = out_valid ? head_entry.instr   : '0;
  assign out_imm_sel = out_valid ? head_entry.imm_sel : '0;
  assign out_illegal = out_valid ? head_entry.illegal : 1'b0;
  assign out_pc      = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign count       = count_q;

endmodule

// File: tb/tb_fetch_buf_ctl.sv
// Bench for fetch_buf_ctl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_buf_ctl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [PC_W-1:0]  in_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic [PC_W-1:0]  out_pc;
  logic [3:0]       out_imm_sel;
  logic             out_illegal;
  logic [CNT_W-1:0] count;

  fetch_buf_ctl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm_sel(out_imm_sel), .out_illegal(out_illegal),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [PC_W-1:0] pc; } ent_t;
  typedef struct { logic [31:0] instr; logic [3:0] imm; } pop_t;

  ent_t model_q[$];
  pop_t popped[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference predecode straight from the opcode table.
  function automatic logic [4:0] ref_pd(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'h37 || op == 7'h17) return {4'd4, 1'b0};
    if (op == 7'h6F) return {4'd5, 1'b0};
    if (op == 7'h67 || op == 7'h03 || op == 7'h13) return {4'd1, 1'b0};
    if (op == 7'h23) return {4'd2, 1'b0};
    if (op == 7'h63) return {4'd3, 1'b0};
    if (op == 7'h33 || op == 7'h0F || op == 7'h73) return {4'd0, 1'b0};
    return {4'd0, 1'b1};
  endfunction

  // Model update and pop capture at the active edge (pre-edge values).
  always @(posedge clk) begin
    bit m_ready, m_valid;
    ent_t e;
    m_ready = (model_q.size() < DEPTH);
    m_valid = (model_q.size() != 0);
    if (!rst && !flush && out_valid && out_ready)
      popped.push_back('{out_instr, out_imm_sel});
    if (rst) begin
      model_q.delete();
      started = 1'b1;
    end else if (flush) begin
      model_q.delete();
    end else begin
      if (m_valid && out_ready) void'(model_q.pop_front());
      if (m_ready && in_valid) begin
        e.instr = in_instr;
        e.pc    = in_pc;
        model_q.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [4:0] pd;
    if (started) begin
      chk("count", 64'(count), 64'(model_q.size()));
      chk("in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        pd = ref_pd(model_q[0].instr);
        chk("out_instr", 64'(out_instr), 64'(model_q[0].instr));
        chk("out_pc", 64'(out_pc), 64'(model_q[0].pc));
        chk("out_imm_sel", 64'(out_imm_sel), 64'(pd[4:1]));
        chk("out_illegal", 64'(out_illegal), 64'(pd[0]));
      end else begin
        chk("out_data_zero", {out_instr, out_pc}, 64'd0);
        chk("out_pd_zero", 64'({out_imm_sel, out_illegal}), 64'd0);
      end
    end
  end

  task automatic push_hold(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    bit r;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int i = 0; i < 40 && !done; i++) begin
      r = in_ready;
      @(negedge clk);
      if (r) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) @(negedge clk);
    chk("drain_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  logic [31:0] seq5 [5] = '{32'h123450B7, 32'h0080006F, 32'h00008067, 32'h00000463, 32'h00112023};
  logic [3:0]  imm5 [5] = '{4'd4, 4'd5, 4'd1, 4'd3, 4'd2};
  logic [6:0]  opc_pool [14] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23,
                                 7'h63, 7'h33, 7'h0F, 7'h73, 7'h0B, 7'h01, 7'h7F};

  initial begin
    logic [31:0] rnd;
    logic [31:0] exp_seq[$];
    bit          prev_ready, was_acc, found;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);

    // ADDI at 0x100 becomes visible the cycle after its push edge.
    push_hold(32'h00500093, 32'h100);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_imm", 64'(out_imm_sel), 64'd1);
    chk("addi_ill", 64'(out_illegal), 64'd0);
    chk("addi_pc", 64'(out_pc), 64'h100);
    chk("addi_count", 64'(count), 64'd1);
    drain();

    // Mixed formats delivered in order.
    popped.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_hold(seq5[i], PC_W'(32'h200 + 4 * i));
    drain();
    chk("seq_len", 64'(popped.size()), 64'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++) begin
      chk("seq_instr", 64'(popped[i].instr), 64'(seq5[i]));
      chk("seq_imm", 64'(popped[i].imm), 64'(imm5[i]));
    end

    // Fill to DEPTH with decode stalled, fifth held until space appears.
    popped.delete();
    for (int i = 0; i < 4; i++) push_hold(32'h00100013 + (i << 20), PC_W'(32'h300 + 4 * i));
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    in_valid = 1'b1;
    in_instr = 32'h00500013;
    in_pc    = 32'h310;
    repeat (3) @(negedge clk);
    chk("full_hold_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    push_hold(32'h00500013, 32'h310);
    drain();
    chk("full_len", 64'(popped.size()), 64'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      chk("full_order", 64'(popped[i].instr), 64'(32'h00100013 + (i << 20)));

    // Steady occupancy of 2 with simultaneous push/pop; pointers wrap.
    popped.delete();
    exp_seq.delete();
    for (int i = 0; i < 2; i++) begin
      push_hold(32'h00000013 + (i << 7), PC_W'(32'h400 + 4 * i));
      exp_seq.push_back(32'h00000013 + (i << 7));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 2; i < 12; i++) begin
      in_instr = 32'h00000013 + (i << 7);
      in_pc    = PC_W'(32'h400 + 4 * i);
      exp_seq.push_back(in_instr);
      @(negedge clk);
      chk("steady_count", 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    drain();
    chk("steady_len", 64'(popped.size()), 64'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < popped.size(); i++)
      chk("steady_order", 64'(popped[i].instr), 64'(exp_seq[i]));

    // Flush overrides a same-cycle push.
    popped.delete();
    for (int i = 0; i < 3; i++) push_hold(32'h00000033, PC_W'(32'h500 + 4 * i));
    chk("pre_flush_count", 64'(count), 64'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hFEED0013;
    in_pc    = 32'h5F0;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    push_hold(32'h00500093, 32'h600);
    drain();
    found = 1'b0;
    foreach (popped[i]) if (popped[i].instr == 32'hFEED0013) found = 1'b1;
    chk("flush_dropped", 64'(found), 64'd0);
    chk("flush_len", 64'(popped.size()), 64'd1);

    // Illegal opcodes are buffered and flagged.
    push_hold(32'h0000000B, 32'h700);
    chk("custom_ill", 64'(out_illegal), 64'd1);
    chk("custom_imm", 64'(out_imm_sel), 64'd0);
    drain();
    push_hold(32'h00000001, 32'h704);
    chk("compr_ill", 64'(out_illegal), 64'd1);
    chk("compr_imm", 64'(out_imm_sel), 64'd0);
    push_hold(32'h00500093, 32'h708);
    chk("pre_rst_count", 64'(count), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", {out_instr, out_pc}, 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);

    // Randomized traffic respecting the hold-until-accepted rule.
    prev_ready = in_ready;
    for (int c = 0; c < 3000; c++) begin
      was_acc = in_valid && prev_ready && !flush && !rst;
      if (!(in_valid && !was_acc && !flush && !rst)) begin
        in_valid = ($urandom_range(0, 99) < 60);
        rnd      = $urandom();
        in_instr = {rnd[31:7], opc_pool[$urandom_range(0, 13)]};
        in_pc    = $urandom();
      end
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 999) < 4);
      prev_ready = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_buf_ctl.md
# fetch_buf_ctl

Parametrised fetch-to-decode buffer with opcode predecode. Accepts fetched instructions with their PC over a valid/ready handshake and predecodes each one into an immediate-format select and an illegal flag. Entries are held in a DEPTH-entry FIFO and presented in order to the decode stage under backpressure, with a single-cycle flush for redirects. It replaces the single-register fetch control stage, adding buffering, handshaking, flush, JALR decode and illegal-opcode detection.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- PC_W, 32, PC width carried alongside each instruction
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset rst, synchronous, active-high
- flush  in  1  discard all entries (branch/jump redirect)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  buffer can accept; equals count < DEPTH
- in_instr  in  32  fetched instruction
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  head entry valid; equals count != 0
- out_ready  in  1  decode accepts head entry
- out_instr  out  32  head instruction
- out_pc  out  PC_W  head PC
- out_imm_sel  out  4  predecoded immediate format of head
- out_illegal  out  1  head opcode unsupported
- count  out  CNT_W  current occupancy

## Operation
- Push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
- Predecode is applied at push and stored with the entry. Opcode = instr[6:0]:
  - 0110111 LUI, 0010111 AUIPC → 4 (U)
  - 1101111 JAL → 5 (J)
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM → 1 (I)
  - 0100011 STORE → 2 (S)
  - 1100011 BRANCH → 3 (B)
  - 0110011 OP, 0001111 FENCE, 1110011 SYSTEM → 0 (none)
  - any other opcode, including instr[1:0] != 2'b11 → imm_sel 0, illegal 1
- Illegal entries are still buffered and delivered in order; decode raises the trap.
- Storage is a DEPTH-entry array indexed by wr_ptr/rd_ptr ($clog2(DEPTH) bits). Pointers wrap naturally modulo DEPTH.
- Outputs read the array at rd_ptr. When out_valid=0, out_instr, out_pc, out_imm_sel and out_illegal are forced to 0.

## Timing
- Reset: wr_ptr=rd_ptr=0 and count=0, so out_valid=0, in_ready=1 and all data outputs are 0. The storage array is not reset.
- Latency: an instruction pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full (count=DEPTH): in_ready=0 and in_valid is ignored. There is no combinational out_ready→in_ready path; a simultaneous pop frees space only from the next cycle.
- Empty: out_ready is ignored.
- Flush: at the next edge pointers and count go to 0. It overrides any push/pop in the same cycle; the push is dropped and nothing is popped. out_valid=0 in the following cycle.
- rst has priority over flush. rst mid-stream discards all contents at the same edge.
- in_valid must stay high with stable in_instr/in_pc until accepted. out_* are stable while out_valid && !out_ready && !flush.

## Structure
- Shared package fetch_pkg: IMM_NONE/I/S/B/U/J localparams (4-bit, values 0–5) and the RV32I opcode constants. Other pipeline control blocks reuse both.
- Sub-module fetch_predecode: combinational; instr[31:0] → imm_sel[3:0], illegal. It is instantiated once, on the push path.
- Top level: pointers, counter, storage array and output masking.

## Test plan
- Reset, then push 0x00500093 (ADDI) at PC 0x100 → next cycle out_valid=1, out_imm_sel=1, out_illegal=0, out_pc=0x100, count=1.
- Push LUI 0x123450B7, JAL 0x0080006F, JALR 0x00008067, BEQ 0x00000463 and SW 0x00112023 with out_ready=1 → delivered in order with imm_sel 4, 5, 1, 3, 2.
- DEPTH=4, out_ready=0, push 5 instructions → in_ready=0 after the 4th, count=4, the 5th is held. Raise out_ready → all 5 emerge in push order.
- Hold count=2 and assert in_valid and out_ready for 10 cycles → count stays 2, order is preserved, and the pointers wrap across index 3→0.
- count=3, flush with in_valid=1 in the same cycle → next cycle count=0 and out_valid=0, and the flushed-cycle instruction never appears.
- Push 0x0000000B (custom-0) and 0x00000001 (compressed) → out_illegal=1, out_imm_sel=0 for each. Assert rst while count=2 → count=0 and all outputs are 0 after the edge.
